// File: rtl/spectro_serial_receiver.sv
// Deserializes the spectrogram readout stream into a timestamp followed by encoded samples.
// Define SPECTRO_RX_TIME_CHECK_EN to add the RTC field check and the time_invalid strobe.
module spectro_serial_receiver #(
  parameter int unsigned TIME_W      = 32,
  parameter int unsigned SAMPLE_W    = 3,
  parameter int unsigned MAX_SAMPLES = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                serial_in,
  input  logic                serial_readout,
  output logic [TIME_W-1:0]   time_out,
  output logic                time_valid,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  output logic [7:0]          sample_index,
  output logic [8:0]          sample_count,
  output logic                frame_done,
  output logic                frame_error,
`ifdef SPECTRO_RX_TIME_CHECK_EN
  output logic                time_invalid,
`endif
  output logic                busy
);

  typedef enum logic [1:0] {
    StIdle,
    StTime,
    StData,
    StDrain
  } state_e;

  state_e state_q, state_d;

  logic [TIME_W-1:0]   shift_q, shift_d;
  logic [TIME_W-1:0]   shift_word;
  logic [5:0]          bitcnt_q, bitcnt_d;
  logic [8:0]          samplecnt_q, samplecnt_d;

  logic [TIME_W-1:0]   time_q, time_d;
  logic                time_valid_q, time_valid_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                sample_valid_q, sample_valid_d;
  logic [7:0]          index_q, index_d;
  logic [8:0]          count_q, count_d;
  logic                frame_done_q, frame_done_d;
  logic                frame_error_q, frame_error_d;

  // Word as it stands once the bit on serial_in is shifted in this cycle.
  assign shift_word = {shift_q[TIME_W-2:0], serial_in};

  // The oldest bit falls off the end of the shift register and is never needed.
  logic unused_shift_msb;
  assign unused_shift_msb = shift_q[TIME_W-1];

  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    bitcnt_d       = bitcnt_q;
    samplecnt_d    = samplecnt_q;
    time_d         = time_q;
    sample_d       = sample_q;
    index_d        = index_q;
    count_d        = count_q;
    time_valid_d   = 1'b0;
    sample_valid_d = 1'b0;
    frame_done_d   = 1'b0;
    frame_error_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (serial_readout) begin
          shift_d  = shift_word;
          bitcnt_d = 6'd1;
          state_d  = StTime;
        end
      end

      StTime: begin
        if (serial_readout) begin
          shift_d = shift_word;
          if (bitcnt_q == 6'(TIME_W - 1)) begin
            time_d       = shift_word;
            time_valid_d = 1'b1;
            bitcnt_d     = 6'd0;
            samplecnt_d  = 9'd0;
            state_d      = StData;
          end else begin
            bitcnt_d = bitcnt_q + 6'd1;
          end
        end else begin
          // Truncated timestamp: drop it and leave time_out untouched.
          frame_error_d = 1'b1;
          state_d       = StIdle;
        end
      end

      StData: begin
        if (serial_readout) begin
          shift_d = shift_word;
          if (bitcnt_q == 6'(SAMPLE_W - 1)) begin
            bitcnt_d = 6'd0;
            if (samplecnt_q < 9'(MAX_SAMPLES)) begin
              sample_d       = shift_word[SAMPLE_W-1:0];
              index_d        = samplecnt_q[7:0];
              sample_valid_d = 1'b1;
              samplecnt_d    = samplecnt_q + 9'd1;
            end else begin
              frame_error_d = 1'b1;
              state_d       = StDrain;
            end
          end else begin
            bitcnt_d = bitcnt_q + 6'd1;
          end
        end else begin
          if (bitcnt_q == 6'd0) begin
            count_d      = samplecnt_q;
            frame_done_d = 1'b1;
          end else begin
            frame_error_d = 1'b1;
          end
          state_d = StIdle;
        end
      end

      StDrain: begin
        if (!serial_readout) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= StIdle;
      shift_q        <= '0;
      bitcnt_q       <= '0;
      samplecnt_q    <= '0;
      time_q         <= '0;
      time_valid_q   <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      index_q        <= '0;
      count_q        <= '0;
      frame_done_q   <= 1'b0;
      frame_error_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      bitcnt_q       <= bitcnt_d;
      samplecnt_q    <= samplecnt_d;
      time_q         <= time_d;
      time_valid_q   <= time_valid_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      index_q        <= index_d;
      count_q        <= count_d;
      frame_done_q   <= frame_done_d;
      frame_error_q  <= frame_error_d;
    end
  end

`ifdef SPECTRO_RX_TIME_CHECK_EN
  // RTC layout: day [31:27], hour [26:22], min [21:16], sec [15:10], millisec [9:0].
  logic time_bad;
  logic time_invalid_q;

  assign time_bad = (shift_word[26:22] > 5'd23)  ||
                    (shift_word[21:16] > 6'd59)  ||
                    (shift_word[15:10] > 6'd59)  ||
                    (shift_word[9:0]   > 10'd999);

  always_ff @(posedge clk) begin
    if (!reset) begin
      time_invalid_q <= 1'b0;
    end else begin
      time_invalid_q <= time_valid_d && time_bad;
    end
  end

  assign time_invalid = time_invalid_q;
`endif

  assign time_out     = time_q;
  assign time_valid   = time_valid_q;
  assign sample_out   = sample_q;
  assign sample_valid = sample_valid_q;
  assign sample_index = index_q;
  assign sample_count = count_q;
  assign frame_done   = frame_done_q;
  assign frame_error  = frame_error_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_spectro_serial_receiver.sv
// Scoreboard bench for spectro_serial_receiver: expected strobes are queued as bits are driven
// and popped as the receiver raises them.
module tb_spectro_serial_receiver;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        serial_in = 1'b0;
  logic        serial_readout = 1'b0;
  logic [31:0] time_out;
  logic        time_valid;
  logic [2:0]  sample_out;
  logic        sample_valid;
  logic [7:0]  sample_index;
  logic [8:0]  sample_count;
  logic        frame_done;
  logic        frame_error;
  logic        busy;
  logic        time_inv;

  spectro_serial_receiver dut (
    .clk            (clk),
    .reset          (reset),
    .serial_in      (serial_in),
    .serial_readout (serial_readout),
    .time_out       (time_out),
    .time_valid     (time_valid),
    .sample_out     (sample_out),
    .sample_valid   (sample_valid),
    .sample_index   (sample_index),
    .sample_count   (sample_count),
    .frame_done     (frame_done),
    .frame_error    (frame_error),
`ifdef SPECTRO_RX_TIME_CHECK_EN
    .time_invalid   (time_inv),
`endif
    .busy           (busy)
  );

`ifndef SPECTRO_RX_TIME_CHECK_EN
  assign time_inv = 1'b0;
`endif

  always #5 clk = ~clk;

  localparam int KTime = 0, KSample = 1, KDone = 2, KError = 3;

  typedef struct {
    int          kind;
    logic [31:0] data;
    logic [8:0]  aux;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [31:0] data, input logic [8:0] aux);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.aux  = aux;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input string tag, input int kind, input logic [31:0] data,
                           input logic [8:0] aux);
    ev_t e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_unexpected"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_kind"}, 32'(kind), 32'(e.kind));
      check_eq({tag, "_data"}, data, e.data);
      check_eq({tag, "_aux"}, 32'(aux), 32'(e.aux));
    end
  endtask

  // Monitor: sample strobes 1 time unit after the rising edge.
  always @(posedge clk) begin
    #1;
    if (frame_done || frame_error)
      check_eq("done_err_excl", 32'(frame_done & frame_error), 32'd0);
    if (time_valid)   pop_check("time", KTime, time_out, 9'(time_inv));
    if (sample_valid) pop_check("sample", KSample, 32'(sample_out), 9'(sample_index));
    if (frame_done)   pop_check("done", KDone, 32'd0, sample_count);
    if (frame_error)  pop_check("error", KError, 32'd0, 9'd0);
  end

  task automatic drive_bit(input logic b);
    @(negedge clk);
    serial_readout = 1'b1;
    serial_in      = b;
  endtask

  task automatic drive_idle();
    @(negedge clk);
    serial_readout = 1'b0;
    serial_in      = 1'b0;
  endtask

  task automatic send_time(input logic [31:0] t, input logic inv);
    for (int i = 31; i >= 0; i--) begin
      if (i == 0) expect_ev(KTime, t, 9'(inv));
      drive_bit(t[i]);
    end
  endtask

  task automatic send_sample(input logic [2:0] v, input int idx);
    for (int i = 2; i >= 0; i--) begin
      if (i == 0) begin
        if (idx < 256) expect_ev(KSample, 32'(v), 9'(idx));
        else           expect_ev(KError, 32'd0, 9'd0);
      end
      drive_bit(v[i]);
    end
  endtask

  task automatic end_frame(input int count);
    expect_ev(KDone, 32'd0, 9'(count));
    drive_idle();
  endtask

  task automatic end_error();
    expect_ev(KError, 32'd0, 9'd0);
    drive_idle();
  endtask

  function automatic logic [31:0] mk_time(input int day, input int hr, input int mn,
                                          input int sec, input int ms);
    return {5'(day), 5'(hr), 6'(mn), 6'(sec), 10'(ms)};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [31:0] t;

    // Reset state.
    repeat (3) @(negedge clk);
    check_eq("rst_time", time_out, 32'd0);
    check_eq("rst_sample", 32'(sample_out), 32'd0);
    check_eq("rst_index", 32'(sample_index), 32'd0);
    check_eq("rst_count", 32'(sample_count), 32'd0);
    check_eq("rst_strobes", 32'({time_valid, sample_valid, frame_done, frame_error}), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;

    // Basic frame.
    send_time(32'h8C41_03E7, 1'b0);
    check_eq("busy_in_frame", 32'(busy), 32'd1);
    send_sample(3'd5, 0);
    send_sample(3'd0, 1);
    send_sample(3'd7, 2);
    end_frame(3);
    repeat (3) @(negedge clk);
    check_eq("idle_after_frame", 32'(busy), 32'd0);

    // Truncated timestamp after 20 bits.
    t = 32'h1234_5678;
    for (int i = 31; i >= 12; i--) drive_bit(t[i]);
    end_error();
    repeat (3) @(negedge clk);
    check_eq("time_kept", time_out, 32'h8C41_03E7);

    // Partial symbol after one sample.
    send_time(mk_time(3, 12, 30, 45, 500), 1'b0);
    send_sample(3'd3, 0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    end_error();
    repeat (3) @(negedge clk);
    check_eq("partial_sample_held", 32'(sample_out), 32'd3);

    // Overlong frame: 257 samples, then drain.
    send_time(mk_time(1, 1, 1, 1, 1), 1'b0);
    for (int k = 0; k <= 256; k++) send_sample(3'(k * 5 + 1), k);
    for (int i = 0; i < 5; i++) drive_bit(1'b1);
    @(negedge clk);
    check_eq("busy_draining", 32'(busy), 32'd1);
    drive_idle();
    repeat (3) @(negedge clk);
    check_eq("idle_after_drain", 32'(busy), 32'd0);
    check_eq("last_index", 32'(sample_index), 32'd255);

    // Reset mid-DATA.
    send_time(mk_time(2, 2, 2, 2, 2), 1'b0);
    send_sample(3'd6, 0);
    drive_bit(1'b1);
    @(negedge clk);
    reset          = 1'b0;
    serial_readout = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_time", time_out, 32'd0);
    check_eq("mid_rst_sample", 32'({sample_out, sample_index, sample_count}), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;

    // Back-to-back frames with one-cycle gap, then a zero-sample frame.
    send_time(32'hA5A5_0F0F, 1'b0);
    send_sample(3'd1, 0);
    send_sample(3'd2, 1);
    end_frame(2);
    send_time(32'h0000_0001, 1'b0);
    send_sample(3'd4, 0);
    end_frame(1);
    send_time(32'hFFFF_FFFF, 1'b0);
    end_frame(0);

`ifdef SPECTRO_RX_TIME_CHECK_EN
    send_time(mk_time(4, 10, 20, 61, 100), 1'b1);
    end_frame(0);
    send_time(mk_time(4, 10, 20, 59, 100), 1'b0);
    end_frame(0);
`endif

    repeat (5) @(negedge clk);
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spectro_serial_receiver.md
# spectro_serial_receiver

Receive-side counterpart of the spectrogram serial readout. Deserializes the one-bit stream produced by the readout chain (`serial_out`, framed by `serial_readout`) back into a 32-bit event timestamp followed by a sequence of 3-bit encoded channel samples. The block sits on the host/FPGA side of the link, clocked by the same serial readout clock that shifted the data out. It presents each decoded word with a one-cycle valid strobe and reports frame completion or framing errors.

## Interface
- `TIME_W`, 32, timestamp width in bits, sent MSB first.
- `SAMPLE_W`, 3, encoded sample width in bits, sent MSB first.
- `MAX_SAMPLES`, 256, maximum samples accepted per frame.
- `clk`  in  1  serial readout clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low; sampled on rising `clk`.
- `serial_in`  in  1  serial data bit.
- `serial_readout`  in  1  frame enable; one data bit is valid on every rising `clk` where high.
- `time_out`  out  TIME_W  last received timestamp.
- `time_valid`  out  1  one-cycle strobe: `time_out` updated.
- `sample_out`  out  SAMPLE_W  last received sample.
- `sample_valid`  out  1  one-cycle strobe: `sample_out`/`sample_index` updated.
- `sample_index`  out  8  zero-based index of `sample_out` within frame.
- `sample_count`  out  9  samples received in the finished frame; valid with `frame_done`.
- `frame_done`  out  1  one-cycle strobe: clean frame end.
- `frame_error`  out  1  one-cycle strobe: truncated or overlong frame.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, TIME, DATA, DRAIN. Shift register TIME_W bits, bit counter 6 bits, sample counter 9 bits.
- IDLE: `serial_readout`=1 -> shift `serial_in` in as first time bit, bitcnt=1, go TIME. Otherwise stay.
- TIME: `serial_readout`=1 -> shift bit; when the TIME_W-th bit is shifted, load `time_out`, pulse `time_valid`, bitcnt=0, samplecnt=0, go DATA. `serial_readout`=0 -> pulse `frame_error`, go IDLE (timestamp discarded, `time_out` unchanged).
- DATA: `serial_readout`=1 -> shift bit; on SAMPLE_W-th bit: if samplecnt < MAX_SAMPLES, load `sample_out`, `sample_index`=samplecnt[7:0], pulse `sample_valid`, samplecnt+1; else pulse `frame_error`, go DRAIN. `serial_readout`=0 -> if bitcnt=0, `sample_count`=samplecnt, pulse `frame_done`; else pulse `frame_error` (partial symbol dropped); go IDLE either way.
- DRAIN: ignore data until `serial_readout`=0, then go IDLE; no further strobes.
- Zero-sample frame (32 bits then `serial_readout` low) is valid: `frame_done` with `sample_count`=0.
- Reset (any state, mid-frame included): state IDLE; all counters, `time_out`, `sample_out`, `sample_index`, `sample_count` = 0; all strobes and `busy` = 0. If `serial_readout` is still high on exit from reset, that bit is treated as the first time bit.

## Timing
- All outputs registered. `time_valid`/`sample_valid` high in the cycle after the edge sampling the word's last bit; data held until next load.
- Back-to-back frames: `serial_readout` may rise in the cycle immediately after the cycle it was low; IDLE accepts it with no gap.
- `frame_done`/`frame_error` asserted in the cycle after the edge where `serial_readout`=0 was sampled; never both in one cycle.
- Throughput: one sample per SAMPLE_W cycles.

## Configuration
- `SPECTRO_RX_TIME_CHECK_EN` defined: timestamp fields checked on load per RTC layout (day [31:27], hour [26:22], min [21:16], sec [15:10], millisec [9:0]); any of hour>23, min>59, sec>59, millisec>999 adds output `time_invalid` (1 bit), a strobe coincident with `time_valid`. Frame continues normally.
- Not defined: no check, no `time_invalid` port.

## Test plan
- Frame: time 0x8C41_03E7, samples 5,0,7, then `serial_readout` low -> `time_valid` with 0x8C41_03E7; three `sample_valid` with values 5,0,7 indices 0,1,2; `frame_done` with `sample_count`=3.
- `serial_readout` low after 20 time bits -> `frame_error`, no `time_valid`, `time_out` keeps prior value.
- `serial_readout` low after 1 sample + 2 bits -> one `sample_valid`, then `frame_error`, no `frame_done`.
- 257 samples -> 256 `sample_valid` (last index 255), `frame_error` on 257th, no strobes until `serial_readout` drops, then idle.
- Reset low mid-DATA for one cycle -> all outputs 0, next rising `serial_readout` decodes a fresh frame correctly; two back-to-back frames with one-cycle gap both complete.
- With `SPECTRO_RX_TIME_CHECK_EN`: timestamp sec field 61 -> `time_invalid` with `time_valid`; sec 59 -> no `time_invalid`.
